pwm_gen: RTL

//  - Downstream consumer of the free-running counter. Shares its clk/rst_n/ena and takes its count.
//  - Converts count into a PWM waveform whose duty is set through a valid/ready update port.
//  - Duty is double-buffered so a new value only takes effect at a period boundary.
//  - Provides run/stop control with full-period start and stop, plus a period-start strobe.

---
 rtl/pwm_gen_pkg.sv | 16 +
 rtl/pwm_duty_buf.sv | 41 ++++
 rtl/pwm_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared state encoding and helpers for the PWM generator.
package pwm_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // True while the generator is producing (or finishing) a PWM period.
  function automatic logic is_active(input state_t s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/pwm_duty_buf.sv
// pwm_duty_buf: double-buffered duty register. A request lands in the pending
// slot (clamped to 2^W) and is promoted to the active duty at a period boundary.
module pwm_duty_buf #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bnd,
  input  logic [W:0]   data,
  input  logic         valid,
  output logic         ready,
  output logic [W:0]   active
);

  localparam logic [W:0] DUTY_MAX = {1'b1, {W{1'b0}}};

  logic [W:0] pend;
  logic       pend_vld;
  logic       accept;

  assign accept = valid && !pend_vld;
  assign ready  = !pend_vld;

  // Pending slot fill on accept, promotion to active at the boundary.
  // Accept needs an empty slot and promotion needs a full one, so they never
  // coincide; a value accepted on a boundary waits for the following one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      active   <= '0;
    end else if (accept) begin
      pend     <= (data > DUTY_MAX) ? DUTY_MAX : data;
      pend_vld <= 1'b1;
    end else if (bnd && pend_vld) begin
      active   <= pend;
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: PWM waveform generator driven by an upstream free-running counter.
// Run/stop FSM with whole-period start and stop, double-buffered duty and a
// period-start strobe. Define PWM_GEN_IRQ_EN to build the sticky irq flag.
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   run,
  input  logic [COUNT_WIDTH:0]   duty_data,
  input  logic                   duty_valid,
  output logic                   duty_ready,
  output logic                   pwm_out,
  output logic                   period_start,
  output logic                   busy,
  output logic                   irq,
  input  logic                   irq_clr
);

  state_t                 state, state_next;
  logic                   bnd;
  logic [COUNT_WIDTH:0]   active;

  // Counter is about to wrap to zero.
  assign bnd  = ena && (count == {COUNT_WIDTH{1'b1}});
  assign busy = (state != S_IDLE);

  pwm_duty_buf #(
    .W (COUNT_WIDTH)
  ) u_duty_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .bnd    (bnd),
    .data   (duty_data),
    .valid  (duty_valid),
    .ready  (duty_ready),
    .active (active)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: starts and stops only take effect at period boundaries.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (run) state_next = S_ARM;
      S_ARM:   if (!run) state_next = S_IDLE;
               else if (bnd) state_next = S_RUN;
      S_RUN:   if (!run) state_next = S_DRAIN;
      S_DRAIN: if (run) state_next = S_RUN;
               else if (bnd) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered compare and period-start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= is_active(state) && ({1'b0, count} < active);
      period_start <= bnd && is_active(state_next);
    end
  end

`ifdef PWM_GEN_IRQ_EN
  // Sticky end-of-period flag; a set on the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         irq <= 1'b0;
    else if (bnd && is_active(state))   irq <= 1'b1;
    else if (irq_clr)                   irq <= 1'b0;
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule
